// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues word reads on the instruction bus,
// and hands instr/pc/exc/slot to the IF/ID register with AdEL, exception and ERET redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI  = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch_d,
  input  logic        taken_d,
  input  logic [31:0] jumpto,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  exc_out,
  output logic        slot_out,
  output logic        f_busy,
  output logic [1:0]  state_dbg
);

  // Bus handshake: imem_req is a level held with imem_addr stable until the
  // single-cycle imem_ack pulse; rdata is only meaningful in the ack cycle.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_READY = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] buffer, buffer_d;
  logic        slot_q, slot_q_d;
  logic [31:0] pend_addr, pend_addr_d;

  logic        bad;
  logic        valid;
  logic        redirect;
  logic        handoff;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  assign bad         = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  assign valid       = ((state == S_REQ) && (bad || imem_ack)) || (state == S_READY);
  assign redirect    = req || eret;
  assign handoff     = valid && !stall && !redirect;
  assign redirect_pc = req ? EXC_PC : epc;
  assign next_pc     = taken_d ? jumpto : pc + 32'd4;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      buffer    <= 32'd0;
      slot_q    <= 1'b0;
      pend_addr <= 32'd0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      buffer    <= buffer_d;
      slot_q    <= slot_q_d;
      pend_addr <= pend_addr_d;
    end
  end

  // Next-state logic; redirects win over stall and handoff.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    buffer_d    = buffer;
    slot_q_d    = slot_q;
    pend_addr_d = pend_addr;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_d     = redirect_pc;
          slot_q_d = 1'b0;
          // An unanswered read must still be drained at its original address.
          if (!bad && !imem_ack) begin
            state_d     = S_DRAIN;
            pend_addr_d = pc;
          end
        end else if (handoff) begin
          pc_d     = next_pc;
          slot_q_d = 1'b0;
        end else if (imem_ack && !bad) begin
          buffer_d = imem_rdata;
          slot_q_d = branch_d;
          state_d  = S_READY;
        end
      end
      S_READY: begin
        if (redirect) begin
          pc_d     = redirect_pc;
          slot_q_d = 1'b0;
          state_d  = S_REQ;
        end else if (handoff) begin
          pc_d     = next_pc;
          slot_q_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output logic.
  always_comb begin
    imem_req  = rst && (((state == S_REQ) && !bad) || (state == S_DRAIN));
    imem_addr = (state == S_DRAIN) ? pend_addr : pc;
    pc_out    = pc;
    f_busy    = !valid;
    exc_out   = ((state == S_REQ) && bad) ? 5'd4 : 5'd0;
    slot_out  = valid && (branch_d || slot_q);
    instr_out = 32'd0;
    if (state == S_READY) begin
      instr_out = buffer;
    end else if ((state == S_REQ) && !bad && imem_ack) begin
      instr_out = imem_rdata;
    end
    state_dbg = state;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scripted bus responder, a scoreboard of
// expected IF/ID handoffs, and immediate assertions at each check point.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        branch_d;
  logic        taken_d;
  logic [31:0] jumpto;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [4:0]  exc_out;
  logic        slot_out;
  logic        f_busy;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  // {instr, pc, exc, slot}
  logic [69:0] exp_q[$];

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req        (req),
    .eret       (eret),
    .epc        (epc),
    .branch_d   (branch_d),
    .taken_d    (taken_d),
    .jumpto     (jumpto),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .exc_out    (exc_out),
    .slot_out   (slot_out),
    .f_busy     (f_busy),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall      = 1'b0;
    req        = 1'b0;
    eret       = 1'b0;
    branch_d   = 1'b0;
    taken_d    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p,
                          input logic [4:0] e, input logic s);
    exp_q.push_back({i, p, e, s});
  endtask

  task automatic check_out(input string tag);
    logic [69:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_instr"}, instr_out, e[69:38]);
      chk({tag, "_pc"},    pc_out,    e[37:6]);
      chk({tag, "_exc"},   {27'd0, exc_out}, {27'd0, e[5:1]});
      chk({tag, "_slot"},  {31'd0, slot_out}, {31'd0, e[0]});
      chk({tag, "_busy"},  {31'd0, f_busy}, 32'd0);
    end
  endtask

  // One wait cycle with the request raised, then an ack with the handoff.
  task automatic deliver(input logic [31:0] a, input logic br, input logic tk,
                         input logic [31:0] tgt, input string tag);
    idle();
    @(negedge clk);
    chk({tag, "_req"},  {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_wbusy"}, {31'd0, f_busy}, 32'd1);
    tick();
    idle();
    imem_ack   = 1'b1;
    imem_rdata = mem(a);
    branch_d   = br;
    taken_d    = tk;
    jumpto     = tgt;
    push_exp(mem(a), a, 5'd0, br);
    @(negedge clk);
    check_out(tag);
    tick();
  endtask

  initial begin
    rst    = 1'b0;
    epc    = 32'd0;
    jumpto = 32'd0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_pc",    pc_out, 32'h0000_3000);
    chk("rst_busy",  {31'd0, f_busy}, 32'd1);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_exc",   {27'd0, exc_out}, 32'd0);
    chk("rst_slot",  {31'd0, slot_out}, 32'd0);
    tick();
    rst = 1'b1;

    deliver(32'h0000_3000, 1'b0, 1'b0, 32'd0, "seq0");
    deliver(32'h0000_3004, 1'b0, 1'b0, 32'd0, "seq1");
    deliver(32'h0000_3008, 1'b0, 1'b0, 32'd0, "seq2");

    // Ack under stall parks the word in READY.
    idle(); stall = 1'b1;
    @(negedge clk);
    chk("stl_addr", imem_addr, 32'h0000_300c);
    tick();
    idle(); stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem(32'h0000_300c);
    push_exp(mem(32'h0000_300c), 32'h0000_300c, 5'd0, 1'b0);
    @(negedge clk);
    chk("stl_ackbusy", {31'd0, f_busy}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1'b1;
      imem_rdata = $urandom_range(32'hffff, 0);
      @(negedge clk);
      chk("stl_noreq", {31'd0, imem_req}, 32'd0);
      chk("stl_instr", instr_out, mem(32'h0000_300c));
      chk("stl_pc",    pc_out, 32'h0000_300c);
      chk("stl_busy",  {31'd0, f_busy}, 32'd0);
      chk("stl_state", {30'd0, state_dbg}, 32'd1);
      tick();
    end
    idle();
    @(negedge clk);
    check_out("stl_rel");
    tick();

    // Taken branch in D: 0x3010 is its delay slot, then 0x3100 is fetched.
    deliver(32'h0000_3010, 1'b1, 1'b1, 32'h0000_3100, "slot1");
    deliver(32'h0000_3100, 1'b1, 1'b1, 32'h0000_3102, "slot2");

    // Misaligned target raises AdEL without a bus request.
    idle(); taken_d = 1'b1; jumpto = 32'h0000_3020;
    push_exp(32'd0, 32'h0000_3102, 5'd4, 1'b0);
    @(negedge clk);
    chk("adel_noreq", {31'd0, imem_req}, 32'd0);
    check_out("adel");
    tick();

    // Exception request during a 4-cycle wait drains the old read.
    idle();
    @(negedge clk);
    chk("drn_addr0", imem_addr, 32'h0000_3020);
    tick();
    idle(); req = 1'b1;
    @(negedge clk);
    chk("drn_busy0", {31'd0, f_busy}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      @(negedge clk);
      chk("drn_req",   {31'd0, imem_req}, 32'd1);
      chk("drn_addr",  imem_addr, 32'h0000_3020);
      chk("drn_busy",  {31'd0, f_busy}, 32'd1);
      chk("drn_pc",    pc_out, 32'h0000_4180);
      chk("drn_state", {30'd0, state_dbg}, 32'd2);
      tick();
    end
    idle(); imem_ack = 1'b1; imem_rdata = mem(32'h0000_3020);
    @(negedge clk);
    chk("drn_ackbusy",  {31'd0, f_busy}, 32'd1);
    chk("drn_ackinstr", instr_out, 32'd0);
    tick();
    idle(); stall = 1'b1;
    @(negedge clk);
    chk("exc_req",  {31'd0, imem_req}, 32'd1);
    chk("exc_addr", imem_addr, 32'h0000_4180);
    chk("exc_busy", {31'd0, f_busy}, 32'd1);
    tick();
    idle(); stall = 1'b1; imem_ack = 1'b1; imem_rdata = mem(32'h0000_4180);
    @(negedge clk);
    chk("exc_ackbusy", {31'd0, f_busy}, 32'd0);
    tick();

    // ERET in READY under stall drops the buffer.
    idle(); stall = 1'b1; eret = 1'b1; epc = 32'h0000_3040;
    @(negedge clk);
    chk("eret_state", {30'd0, state_dbg}, 32'd1);
    chk("eret_instr", instr_out, mem(32'h0000_4180));
    tick();
    deliver(32'h0000_3040, 1'b0, 1'b0, 32'd0, "eret");

    // Reset asserted mid-wait takes effect immediately.
    idle();
    @(negedge clk);
    chk("mrst_addr", imem_addr, 32'h0000_3044);
    #1 rst = 1'b0;
    #1;
    chk("mrst_pc",    pc_out, 32'h0000_3000);
    chk("mrst_req",   {31'd0, imem_req}, 32'd0);
    chk("mrst_busy",  {31'd0, f_busy}, 32'd1);
    chk("mrst_state", {30'd0, state_dbg}, 32'd0);
    tick();
    rst = 1'b1;
    deliver(32'h0000_3000, 1'b0, 1'b0, 32'd0, "post_rst");

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage fetch engine. Owns the PC and issues word reads to the instruction bus.
- Presents each fetched instruction to the IF/ID pipeline register as instr/pc/exc/slot, which is the interface the D-stage register consumes.
- Handles variable-latency bus responses, AdEL detection, delay-slot marking, exception entry (0x4180) and ERET redirect.
- Drives f_busy into the hazard unit, which ORs it into the D-stage stall.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  1  D stage holding; the current instruction must not be handed off.
- req  in  1  exception/interrupt entry from CP0; redirect to EXC_PC.
- eret  in  1  ERET committed; redirect to epc.
- epc  in  32  return address for eret.
- branch_d  in  1  instruction in D is a branch/jump, so the instruction now in F is its delay slot.
- taken_d  in  1  D branch/jump resolved taken.
- jumpto  in  32  target of the D branch/jump.
- imem_req  out  1  bus read request (level).
- imem_addr  out  32  bus address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response pulse; data valid the same cycle.
- imem_rdata  in  32  read data.
- instr_out  out  32  instruction to IF/ID; 0 (nop) when exc_out≠0 or not valid.
- pc_out  out  32  PC of instr_out.
- exc_out  out  5  exception code; 4 (AdEL) or 0.
- slot_out  out  1  instr_out is a delay-slot instruction.
- f_busy  out  1  no valid instruction this cycle; the D stage must treat it as stall.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=REQ, buffer=0, slot_q=0, pend=0.
  - Outputs: imem_req=0 while in reset, instr_out=0, pc_out=RESET_PC, exc_out=0, slot_out=0, f_busy=1.
- pc_out = pc register at all times.
- AdEL: bad = pc[1:0]≠0 OR pc<TEXT_LO OR pc>TEXT_HI (unsigned).
  - If bad, no bus request is issued.
  - The instruction is immediately valid with instr_out=0 and exc_out=4.
- State REQ:
  - imem_req=1 and imem_addr=pc when !bad.
  - The cycle the request is raised counts as the first wait cycle.
  - On imem_ack, rdata is valid combinationally the same cycle.
- valid = (state REQ AND (bad OR imem_ack)) OR state READY. f_busy = !valid.
- Handoff: valid AND !stall AND !req AND !eret.
  - pc <= taken_d ? jumpto : pc+4 (32-bit wrap, no check; the next fetch is checked for AdEL).
  - slot_q <= 0. State stays REQ.
- Capture: valid from ack in REQ AND stall → buffer <= imem_rdata; state READY.
  - READY presents the buffer with f_busy=0 until handoff.
  - The bus is idle while in READY.
- slot_out = branch_d, sampled combinationally while valid.
  - A D-stage stall keeps branch_d stable, so no latching is needed beyond slot_q.
- Redirect priority: rst > req > eret > stall/handoff.
  - req: pc <= EXC_PC. eret: pc <= epc. Both override stall.
  - If a bus read is outstanding (REQ, !bad, no ack this cycle): go to DRAIN and keep imem_req=1 at the old address until ack.
  - On ack in DRAIN, discard the data and go to REQ at the new pc. f_busy=1 throughout DRAIN.
  - A new req/eret during DRAIN updates pc again; the last redirect wins.
  - If no read is outstanding (READY, bad, or ack this cycle): go directly to REQ at the new pc; the buffer is discarded.
- Branch redirect never cancels the delay slot.
  - The delay slot is always delivered.
  - Its successor address comes from taken_d/jumpto at the delay slot's handoff.
- The ack is ignored outside REQ and DRAIN.

Test Plan:
- Reset release, bus ack 1 cycle after request, stall=0:
  - pc_out 0x3000→0x3004→0x3008.
  - Each instruction is presented with f_busy=0 on its ack cycle.
- Ack arrives while stall=1 for 3 cycles:
  - READY holds instr_out=rdata and pc_out constant.
  - No second imem_req until handoff; the next pc is +4.
- branch_d=1, taken_d=1, jumpto=0x3100 while fetching 0x3010:
  - 0x3010 is delivered with slot_out=1.
  - The next imem_addr is 0x3100.
- jumpto=0x3102 taken:
  - The next fetch issues no imem_req.
  - instr_out=0, exc_out=4, pc_out=0x3102, f_busy=0.
- req pulsed 1 cycle into a 4-cycle bus wait at 0x3020:
  - imem_req stays on addr 0x3020 until ack; the data is dropped.
  - The next request is to 0x4180; f_busy=1 throughout.
- eret with epc=0x3040 while stall=1 in READY:
  - The buffer is dropped and the next fetch is 0x3040 with slot_out=0.
  - rst=0 asserted mid-wait returns pc_out=0x3000 immediately.
